// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: icache/dcache request/ack ports plus the MainMem port.
// 'slave' is the arbiter's view, 'master' is the environment (caches + memory).
interface mem_arbiter_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ack;
  logic [31:0] ic_rdata;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_ack;
  logic [31:0] dc_rdata;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    output ic_ack, ic_rdata, dc_ack, dc_rdata, mem_oe, mem_we, mem_addr, mem_wdata,
           busy, timeout_err
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    input  ic_ack, ic_rdata, dc_ack, dc_rdata, mem_oe, mem_we, mem_addr, mem_wdata,
           busy, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing MainMem between icache refill and dcache; one transaction at a time.
// Latency req->ack is 2 cycles minimum; a watchdog aborts a transaction that never sees mem_ready.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  state_t           state_q;
  logic             last_d_q;
  logic             dc_we_q;
  logic [CNT_W-1:0] wd_q;
  logic             ic_ack_q;
  logic             dc_ack_q;
  logic [31:0]      ic_rdata_q;
  logic [31:0]      dc_rdata_q;
  logic             mem_oe_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic             busy_q;
  logic             timeout_err_q;

  logic             pick_d;
  logic [CNT_W:0]   wd_inc;
  logic             serve_end;

  // D wins when alone, or on a tie when I was granted last.
  assign pick_d    = bus.dc_req && (!bus.ic_req || !last_d_q);
  assign wd_inc    = {1'b0, wd_q} + (CNT_W+1)'(1);
  assign serve_end = bus.mem_ready || (wd_inc == TO_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b0;
      dc_we_q       <= 1'b0;
      wd_q          <= '0;
      ic_ack_q      <= 1'b0;
      dc_ack_q      <= 1'b0;
      ic_rdata_q    <= '0;
      dc_rdata_q    <= '0;
      mem_oe_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ic_req || bus.dc_req) begin
            busy_q <= 1'b1;
            wd_q   <= '0;
            if (pick_d) begin
              state_q     <= SERVE_D;
              last_d_q    <= 1'b1;
              dc_we_q     <= bus.dc_we;
              mem_addr_q  <= bus.dc_addr;
              mem_wdata_q <= bus.dc_wdata;
              mem_we_q    <= bus.dc_we;
              mem_oe_q    <= !bus.dc_we;
            end else begin
              state_q     <= SERVE_I;
              last_d_q    <= 1'b0;
              dc_we_q     <= 1'b0;
              mem_addr_q  <= bus.ic_addr;
              mem_wdata_q <= '0;
              mem_we_q    <= 1'b0;
              mem_oe_q    <= 1'b1;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (serve_end) begin
            state_q  <= DONE;
            mem_oe_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (state_q == SERVE_I) ic_ack_q <= 1'b1;
            else                    dc_ack_q <= 1'b1;
            if (bus.mem_ready) begin
              if (state_q == SERVE_I) ic_rdata_q <= bus.mem_rdata;
              else if (!dc_we_q)      dc_rdata_q <= bus.mem_rdata;
            end else begin
              // Watchdog abort: the requester still gets its ack, with poisoned data.
              timeout_err_q <= 1'b1;
              if (state_q == SERVE_I) ic_rdata_q <= ERR_DATA;
              else                    dc_rdata_q <= ERR_DATA;
            end
          end else begin
            wd_q <= wd_inc[CNT_W-1:0];
          end
        end
        DONE: begin
          state_q  <= IDLE;
          ic_ack_q <= 1'b0;
          dc_ack_q <= 1'b0;
          wd_q     <= '0;
          busy_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ic_ack      = ic_ack_q;
  assign bus.dc_ack      = dc_ack_q;
  assign bus.ic_rdata    = ic_rdata_q;
  assign bus.dc_rdata    = dc_rdata_q;
  assign bus.mem_oe      = mem_oe_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-exact vector table plus timeout and mid-transaction reset sequences.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_if bus();

  mem_arbiter #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(8),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: {ic_ack, dc_ack, mem_oe, mem_we, busy, timeout_err}
  typedef struct {
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [5:0]  e_flags;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_ic_rd;
    logic [31:0] e_dc_rd;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mrd,
                              input logic mr, input logic [5:0] fl, input logic [31:0] ea,
                              input logic [31:0] ew, input logic [31:0] eir, input logic [31:0] edr);
    vec_t v;
    v.ic_req = ir;  v.ic_addr = ia;  v.dc_req = dr;  v.dc_we = dw;
    v.dc_addr = da; v.dc_wdata = dd; v.mem_rdata = mrd; v.mem_ready = mr;
    v.e_flags = fl; v.e_addr = ea;   v.e_wdata = ew;
    v.e_ic_rd = eir; v.e_dc_rd = edr;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {26'd0, bus.ic_ack, bus.dc_ack, bus.mem_oe, bus.mem_we, bus.busy, bus.timeout_err};
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mrd,
                       input logic mr);
    bus.ic_req = ir;  bus.ic_addr = ia;   bus.dc_req = dr;     bus.dc_we = dw;
    bus.dc_addr = da; bus.dc_wdata = dd;  bus.mem_rdata = mrd; bus.mem_ready = mr;
  endtask

  // Exclusivity of acks and of strobes, every cycle out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1)
      chk("excl", 0, {30'd0, bus.ic_ack & bus.dc_ack, bus.mem_oe & bus.mem_we}, 32'd0);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Cycle-by-cycle table; row i is driven and checked in cycle i after reset release.
    // Tie after reset (D first), sustained contention D,I,D,I, dc write, ic read.
    tbl[0]  = mk(1, 32'h300, 1, 0, 32'h200, 32'h11111111, 32'h0,        0, 6'b000000, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[1]  = mk(1, 32'h300, 1, 0, 32'h200, 32'h11111111, 32'hAAAA0001, 1, 6'b001010, 32'h200, 32'h11111111, 32'h0,        32'h0);
    tbl[2]  = mk(1, 32'h300, 0, 0, 32'h200, 32'h11111111, 32'h0,        0, 6'b010010, 32'h200, 32'h11111111, 32'h0,        32'hAAAA0001);
    tbl[3]  = mk(1, 32'h300, 0, 0, 32'h200, 32'h11111111, 32'h0,        0, 6'b000000, 32'h200, 32'h11111111, 32'h0,        32'hAAAA0001);
    tbl[4]  = mk(1, 32'h300, 0, 0, 32'h200, 32'h11111111, 32'hBBBB0002, 1, 6'b001010, 32'h300, 32'h0,        32'h0,        32'hAAAA0001);
    tbl[5]  = mk(0, 32'h300, 0, 0, 32'h200, 32'h11111111, 32'h0,        0, 6'b100010, 32'h300, 32'h0,        32'hBBBB0002, 32'hAAAA0001);
    tbl[6]  = mk(1, 32'h400, 1, 1, 32'h500, 32'hCAFE0001, 32'h0,        0, 6'b000000, 32'h300, 32'h0,        32'hBBBB0002, 32'hAAAA0001);
    tbl[7]  = mk(1, 32'h400, 1, 1, 32'h500, 32'hCAFE0001, 32'h0,        0, 6'b000110, 32'h500, 32'hCAFE0001, 32'hBBBB0002, 32'hAAAA0001);
    tbl[8]  = mk(1, 32'h400, 1, 1, 32'h500, 32'hCAFE0001, 32'hFFFF0000, 1, 6'b000110, 32'h500, 32'hCAFE0001, 32'hBBBB0002, 32'hAAAA0001);
    tbl[9]  = mk(1, 32'h400, 1, 1, 32'h500, 32'hCAFE0001, 32'h0,        0, 6'b010010, 32'h500, 32'hCAFE0001, 32'hBBBB0002, 32'hAAAA0001);
    tbl[10] = mk(1, 32'h400, 1, 1, 32'h500, 32'hCAFE0001, 32'h0,        0, 6'b000000, 32'h500, 32'hCAFE0001, 32'hBBBB0002, 32'hAAAA0001);
    tbl[11] = mk(1, 32'h400, 1, 1, 32'h500, 32'hCAFE0001, 32'h44440004, 1, 6'b001010, 32'h400, 32'h0,        32'hBBBB0002, 32'hAAAA0001);
    tbl[12] = mk(1, 32'h400, 1, 1, 32'h500, 32'hCAFE0001, 32'h0,        0, 6'b100010, 32'h400, 32'h0,        32'h44440004, 32'hAAAA0001);
    tbl[13] = mk(1, 32'h400, 1, 0, 32'h504, 32'hCAFE0002, 32'h0,        0, 6'b000000, 32'h400, 32'h0,        32'h44440004, 32'hAAAA0001);
    tbl[14] = mk(1, 32'h400, 1, 0, 32'h504, 32'hCAFE0002, 32'h55550005, 1, 6'b001010, 32'h504, 32'hCAFE0002, 32'h44440004, 32'hAAAA0001);
    tbl[15] = mk(1, 32'h400, 1, 0, 32'h504, 32'hCAFE0002, 32'h0,        0, 6'b010010, 32'h504, 32'hCAFE0002, 32'h44440004, 32'h55550005);
    tbl[16] = mk(1, 32'h408, 1, 0, 32'h504, 32'hCAFE0002, 32'h0,        0, 6'b000000, 32'h504, 32'hCAFE0002, 32'h44440004, 32'h55550005);
    tbl[17] = mk(1, 32'h408, 0, 0, 32'h504, 32'hCAFE0002, 32'h0,        0, 6'b001010, 32'h408, 32'h0,        32'h44440004, 32'h55550005);
    tbl[18] = mk(1, 32'h408, 0, 0, 32'h504, 32'hCAFE0002, 32'h66660006, 1, 6'b001010, 32'h408, 32'h0,        32'h44440004, 32'h55550005);
    tbl[19] = mk(0, 32'h408, 0, 0, 32'h504, 32'hCAFE0002, 32'h0,        0, 6'b100010, 32'h408, 32'h0,        32'h66660006, 32'h55550005);
    tbl[20] = mk(0, 32'h408, 0, 0, 32'h504, 32'hCAFE0002, 32'h77770007, 1, 6'b000000, 32'h408, 32'h0,        32'h66660006, 32'h55550005);
    tbl[21] = mk(0, 32'h408, 0, 0, 32'h504, 32'hCAFE0002, 32'h0,        0, 6'b000000, 32'h408, 32'h0,        32'h66660006, 32'h55550005);
    tbl[22] = mk(0, 32'h0,   1, 1, 32'h100, 32'hA5A5A5A5, 32'h0,        0, 6'b000000, 32'h408, 32'h0,        32'h66660006, 32'h55550005);
    tbl[23] = mk(0, 32'h0,   1, 1, 32'h100, 32'hA5A5A5A5, 32'h0,        0, 6'b000110, 32'h100, 32'hA5A5A5A5, 32'h66660006, 32'h55550005);
    tbl[24] = mk(0, 32'h0,   1, 1, 32'h100, 32'hA5A5A5A5, 32'h0,        0, 6'b000110, 32'h100, 32'hA5A5A5A5, 32'h66660006, 32'h55550005);
    tbl[25] = mk(0, 32'h0,   1, 1, 32'h100, 32'hA5A5A5A5, 32'h99999999, 1, 6'b000110, 32'h100, 32'hA5A5A5A5, 32'h66660006, 32'h55550005);
    tbl[26] = mk(0, 32'h0,   0, 0, 32'h100, 32'hA5A5A5A5, 32'h0,        0, 6'b010010, 32'h100, 32'hA5A5A5A5, 32'h66660006, 32'h55550005);
    tbl[27] = mk(0, 32'h0,   0, 0, 32'h100, 32'hA5A5A5A5, 32'h0,        0, 6'b000000, 32'h100, 32'hA5A5A5A5, 32'h66660006, 32'h55550005);
    tbl[28] = mk(1, 32'h40,  0, 0, 32'h100, 32'hA5A5A5A5, 32'h0,        0, 6'b000000, 32'h100, 32'hA5A5A5A5, 32'h66660006, 32'h55550005);
    tbl[29] = mk(1, 32'h40,  0, 0, 32'h100, 32'hA5A5A5A5, 32'h12345678, 1, 6'b001010, 32'h40,  32'h0,        32'h66660006, 32'h55550005);
    tbl[30] = mk(0, 32'h40,  0, 0, 32'h100, 32'hA5A5A5A5, 32'h0,        0, 6'b100010, 32'h40,  32'h0,        32'h12345678, 32'h55550005);
    tbl[31] = mk(0, 32'h40,  0, 0, 32'h100, 32'hA5A5A5A5, 32'h0,        0, 6'b000000, 32'h40,  32'h0,        32'h12345678, 32'h55550005);

    reset = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    repeat (3) @(negedge clk);
    chk("rst_flags", 0, flags(), 32'd0);
    chk("rst_addr", 0, bus.mem_addr, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ic_req, tbl[i].ic_addr, tbl[i].dc_req, tbl[i].dc_we,
            tbl[i].dc_addr, tbl[i].dc_wdata, tbl[i].mem_rdata, tbl[i].mem_ready);
      #1;
      chk("flags", i, flags(), {26'd0, tbl[i].e_flags});
      chk("mem_addr", i, bus.mem_addr, tbl[i].e_addr);
      chk("mem_wdata", i, bus.mem_wdata, tbl[i].e_wdata);
      chk("ic_rdata", i, bus.ic_rdata, tbl[i].e_ic_rd);
      chk("dc_rdata", i, bus.dc_rdata, tbl[i].e_dc_rd);
      @(negedge clk);
    end

    // Watchdog abort on a dc read with TIMEOUT_CYCLES=4.
    drive(0, 32'h0, 1, 0, 32'h700, 32'h0, 32'h0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.dc_req = 1'b0;
      #1;
      chk("to_strobe", c, flags(), 32'b001010);
      chk("to_addr", c, bus.mem_addr, 32'h700);
    end
    @(negedge clk);
    #1;
    chk("to_ack_flags", 5, flags(), 32'b010011);
    chk("to_rdata", 5, bus.dc_rdata, 32'hDEADBEEF);
    chk("to_ic_rdata", 5, bus.ic_rdata, 32'h12345678);
    repeat (20) @(negedge clk);
    #1;
    chk("to_sticky", 25, flags(), 32'b000001);

    // Reset asserted while serving a dc read.
    @(negedge clk);
    drive(0, 32'h0, 1, 0, 32'h800, 32'h0, 32'h0, 0);
    @(negedge clk);
    bus.dc_req = 1'b0;
    #1;
    chk("mid_serve", 0, flags(), 32'b001011);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_flags", 0, flags(), 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    chk("mid_rst_hold", 0, flags(), 32'd0);
    chk("mid_rst_dc_rdata", 0, bus.dc_rdata, 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_idle", c, flags(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
